// File: rtl/sdram_wt_cache_pkg.sv
// Shared types and helpers for the SDRAM write-through word cache.
// Holds the FSM state enum, bus width constants and address field extraction.
// Pure declarations; no logic, no latency, no backpressure.
package sdram_cache_pkg;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MEM_RD,
    S_MEM_WR,
    S_RESP
  } state_t;

  // Line index: word address bits just above the byte offset.
  function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] addr,
                                                   input int idx_w);
    return (addr >> 2) & ((ADDR_W'(1) << idx_w) - ADDR_W'(1));
  endfunction

  // Tag: everything above the index field.
  function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr,
                                                 input int idx_w);
    return addr >> (2 + idx_w);
  endfunction

endpackage

// File: rtl/sdram_wt_cache_if.sv
// Valid/ready pulse bus used on both the CPU side and the SDRAM controller side.
// master drives addr/din/wmask/valid and receives dout/ready; slave is the mirror.
// ready is a one-cycle completion pulse; the master holds valid and payload until then.
interface sdram_wt_cache_if;
  import sdram_cache_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [MASK_W-1:0] wmask;
  logic              valid;
  logic [DATA_W-1:0] dout;
  logic              ready;

  modport master (output addr, din, wmask, valid, input dout, ready);
  modport slave  (input addr, din, wmask, valid, output dout, ready);
endinterface

// File: rtl/sdram_cache_array.sv
// Valid/tag/data storage for the direct-mapped cache, one word per line.
// Read port is combinational (0 cycles); write port takes effect on the next clk edge.
// No backpressure: a write is accepted every cycle wr_en is high.
// Ports: rd_idx -> rd_valid/rd_tag/rd_data; wr_en/wr_idx/wr_tag/wr_data/wr_mask/wr_set_valid.
module sdram_cache_array
  import sdram_cache_pkg::*;
#(
  parameter int LINES = 256,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 23 - IDX_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [MASK_W-1:0] wr_mask,
  input  logic              wr_set_valid
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  // Only the valid bits are reset; stale tag/data are harmless behind valid=0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
    end else if (wr_en && wr_set_valid) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_tag;
      for (int i = 0; i < MASK_W; i++) begin
        if (wr_mask[i]) data_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/sdram_wt_cache.sv
// Direct-mapped write-through, no-write-allocate word cache in front of the SDRAM controller.
// Read hit: cpu ready 2 cycles after request is sampled; miss/write: SDRAM latency + 3.
// One request in flight; cpu valid is ignored until the completion pulse has passed.
// Ports: clk, resetn, cpu (slave bus from CPU), mem (master bus to controller);
// optional hit_count/miss_count read-statistics outputs when SDRAM_CACHE_STATS_EN is defined.
module sdram_wt_cache
  import sdram_cache_pkg::*;
#(
  parameter  int LINES = 256,
  localparam int IDX_W = $clog2(LINES),
  localparam int TAG_W = 23 - IDX_W
) (
  input  logic              clk,
  input  logic              resetn,
  sdram_wt_cache_if.slave   cpu,
  sdram_wt_cache_if.master  mem
`ifdef SDRAM_CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  state_t state, state_nxt;

  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_din;
  logic [MASK_W-1:0] req_wmask;
  logic [DATA_W-1:0] cpu_dout_q;
  logic              mem_valid_q;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              arr_valid;
  logic [TAG_W-1:0]  arr_tag;
  logic [DATA_W-1:0] arr_data;
  logic              hit;
  logic              is_read;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [MASK_W-1:0] wr_mask;

  assign req_idx = IDX_W'(addr_index(req_addr, IDX_W));
  assign req_tag = TAG_W'(addr_tag(req_addr, IDX_W));
  assign is_read = (req_wmask == '0);
  assign hit     = arr_valid && (arr_tag == req_tag);

  // Write hits merge into the line during LOOKUP; read-miss fills land with mem ready.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = req_din;
    wr_mask = req_wmask;
    if (state == S_LOOKUP && !is_read && hit) begin
      wr_en = 1'b1;
    end else if (state == S_MEM_RD && mem.ready) begin
      wr_en   = 1'b1;
      wr_data = mem.dout;
      wr_mask = '1;
    end
  end

  sdram_cache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk          (clk),
    .resetn       (resetn),
    .rd_idx       (req_idx),
    .rd_valid     (arr_valid),
    .rd_tag       (arr_tag),
    .rd_data      (arr_data),
    .wr_en        (wr_en),
    .wr_idx       (req_idx),
    .wr_tag       (req_tag),
    .wr_data      (wr_data),
    .wr_mask      (wr_mask),
    .wr_set_valid (1'b1)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cpu.valid && !cpu.ready) state_nxt = S_LOOKUP;
      S_LOOKUP: begin
        if (is_read && hit) state_nxt = S_RESP;
        else if (is_read)   state_nxt = S_MEM_RD;
        else                state_nxt = S_MEM_WR;
      end
      S_MEM_RD: if (mem.ready) state_nxt = S_RESP;
      S_MEM_WR: if (mem.ready) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Request registers only load in IDLE, so they (and the mem bus) stay put
  // for the whole time mem valid is high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_addr    <= '0;
      req_din     <= '0;
      req_wmask   <= '0;
      cpu_dout_q  <= '0;
      mem_valid_q <= 1'b0;
    end else begin
      if (state == S_IDLE && cpu.valid && !cpu.ready) begin
        req_addr  <= cpu.addr;
        req_din   <= cpu.din;
        req_wmask <= cpu.wmask;
      end
      if (state == S_LOOKUP) begin
        if (is_read && hit) cpu_dout_q  <= arr_data;
        else                mem_valid_q <= 1'b1;
      end
      if ((state == S_MEM_RD || state == S_MEM_WR) && mem.ready) begin
        mem_valid_q <= 1'b0;
        if (state == S_MEM_RD) cpu_dout_q <= mem.dout;
      end
    end
  end

`ifdef SDRAM_CACHE_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == S_LOOKUP && is_read) begin
      if (hit) hit_count  <= hit_count + 32'd1;
      else     miss_count <= miss_count + 32'd1;
    end
  end
`endif

  assign cpu.ready = (state == S_RESP);
  assign cpu.dout  = cpu_dout_q;
  assign mem.addr  = {req_addr[ADDR_W-1:2], 2'b00};
  assign mem.din   = req_din;
  assign mem.wmask = req_wmask;
  assign mem.valid = mem_valid_q;

endmodule

// File: doc/sdram_wt_cache.md
# sdram_wt_cache

Direct-mapped, write-through, no-write-allocate word cache between the CPU data bus and the SDRAM controller. It implements the same valid/ready pulse protocol on both sides, so it drops in transparently in front of the controller. Read hits return without touching SDRAM. Every write is forwarded to SDRAM; write hits also update the cached line.

## Interface
Parameters:
- LINES, 256, number of one-word lines; power of two, ≥2. IDX_W = log2(LINES), TAG_W = 23 − IDX_W.

Ports:
- clk  in  1  clock, shared with the SDRAM controller
- resetn  in  1  reset. One clock; reset is asynchronous and active-low.
- cpu_addr  in  25  byte address; bits [1:0] ignored
- cpu_din  in  32  write data
- cpu_wmask  in  4  byte write enables; 0 = read
- cpu_valid  in  1  request; held until cpu_ready
- cpu_dout  out  32  read data, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- mem_addr  out  25  to controller addr; bits [1:0] forced 0
- mem_din  out  32  to controller din
- mem_wmask  out  4  to controller wmask
- mem_valid  out  1  to controller valid
- mem_dout  in  32  from controller dout
- mem_ready  in  1  from controller ready (one-cycle pulse)

## Operation
- Address split: index = cpu_addr[2 +: IDX_W], tag = cpu_addr[24 : 2+IDX_W].
- Per line: valid bit, TAG_W-bit tag, 32-bit data.
- FSM states: IDLE, LOOKUP, MEM_RD, MEM_WR, RESP.
- IDLE: on cpu_valid && !cpu_ready, latch addr/din/wmask into request registers and go to LOOKUP. The latched copy drives everything downstream.
- LOOKUP: hit = valid[index] && tag match.
  - Read hit: cpu_dout ← line data, go to RESP.
  - Read miss: mem_valid=1, mem_wmask=0, go to MEM_RD.
  - Write, hit or miss: mem_valid=1 with latched din/wmask, go to MEM_WR.
  - Write hit only: merge din into the line per wmask (byte i updated iff wmask[i]) in this same cycle.
- MEM_RD: wait for mem_ready. On mem_ready:
  - fill data ← mem_dout, tag ← tag, valid ← 1;
  - cpu_dout ← mem_dout; clear mem_valid; go to RESP.
- MEM_WR: wait for mem_ready. On mem_ready: clear mem_valid, go to RESP. A write miss never allocates.
- RESP: cpu_ready=1 for exactly one cycle, then IDLE.
- mem_valid is registered and cleared on the edge where mem_ready=1. It is never high while mem_ready is high on the following cycle.
- The request registers (and therefore mem_addr, mem_din, mem_wmask) are stable for the whole time mem_valid is high. The controller samples addr again after activation, so this stability is required.
- A read miss overwrites the indexed line regardless of its previous contents.
- cpu_valid is ignored outside IDLE, and ignored in the cycle cpu_ready is high.

## Timing
- Reset values: cpu_ready=0, cpu_dout=0, mem_valid=0, mem_addr=0, mem_din=0, mem_wmask=0, state=IDLE, all valid bits=0. Tag and data arrays are not reset.
- Read hit: cpu_valid sampled at edge 0, LOOKUP at edge 1, cpu_ready high in cycle 2. Latency is 2 cycles.
- Miss or write: mem_valid rises 2 cycles after cpu_valid is sampled. cpu_ready rises 1 cycle after mem_ready. Total = SDRAM latency + 3.
- Back-to-back: a new request can be accepted in the cycle after cpu_ready falls.
- Reset mid-transaction: async return to IDLE and all lines invalidated. The controller shares resetn, so no orphaned SDRAM transaction remains.

## Configuration
- SDRAM_CACHE_STATS_EN defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], async reset to 0.
  - Each counter increments by 1 once per LOOKUP, on read hit and read miss respectively; writes are not counted.
  - Counters wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package sdram_cache_pkg holds:
  - the FSM state enum;
  - the address-field width constants ADDR_W=25, DATA_W=32, MASK_W=4;
  - the index/tag extraction functions, parameterised by IDX_W.
- One sub-module, sdram_cache_array:
  - holds the valid/tag/data storage;
  - one combinational read port (index → valid, tag, data);
  - one write port (index, tag, data, byte mask, set-valid).
- The top module contains the FSM, the request registers and the optional counters.

## Test plan
- Cold read of 0x0000100: controller model returns 0xDEADBEEF after 10 cycles → one mem_valid transaction with wmask=0; cpu_dout=0xDEADBEEF; miss_count=1.
- Repeat read of 0x0000100 → cpu_ready 2 cycles after request, no mem_valid, cpu_dout=0xDEADBEEF, hit_count=1.
- Write 0x000000AA with wmask=4'b0001 to 0x0000100, then read → SDRAM sees the write with wmask=0001; the read hits and returns 0xDEADBEAA.
- Write to uncached 0x0000200, then read 0x0000200 → the read misses (no allocate on write) and fetches from SDRAM.
- Conflict (LINES=256): read 0x0000100, read 0x0000500, read 0x0000100 → three misses; the line is refilled each time.
- Assert resetn low while in MEM_RD → mem_valid=0 immediately; the next read of a previously cached address misses.
